// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants and the receiver/transmitter FSM state encoding.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        WAIT_HI
    } rx_state_t;

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial input plus frame-result bundle of the configurable UART receiver.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_RX_Serial;
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;
    logic                 o_Busy;

    // Receiver side: consumes the line, produces the frame results.
    modport master (
        input  i_RX_Serial,
        output o_RX_DV, o_RX_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
    );

    // Line driver / command decoder side.
    modport slave (
        output i_RX_Serial,
        input  o_RX_DV, o_RX_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic i_Async,
    output logic o_Sync
);
    logic r_meta;
    logic r_sync;

    // NOTE: reset to 1, not 0 -- a 0 here would look like a start bit right after reset.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_Async;
            r_sync <= r_meta;
        end
    end

    assign o_Sync = r_sync;
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits,
// false-start rejection and parity/framing/break reporting, one o_RX_DV pulse per frame.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic          i_Clock,
    input  logic          i_Rst_L,
    uart_rx_cfg_if.master io_Rx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam bit               HAS_PARITY = (PARITY_MODE != PARITY_NONE);
    localparam bit               ODD_PARITY = (PARITY_MODE == PARITY_ODD);

    logic                 w_rx;
    logic                 w_last_stop;
    logic                 w_frame_err;
    logic                 w_break;

    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_stop_idx;
    logic                 r_frame_acc;
    logic                 r_par_bit;
    logic                 r_par_err;

    uart_rx_sync u_sync (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .i_Async (io_Rx.i_RX_Serial),
        .o_Sync  (w_rx)
    );

    // Frame verdict as it stands on the edge that samples the final stop bit.
    assign w_last_stop = (STOP_BITS == 1) || r_stop_idx;
    assign w_frame_err = r_frame_acc | ~w_rx;
    assign w_break     = w_frame_err && (r_data == '0) && (!HAS_PARITY || !r_par_bit);

    // NOTE: all FSM state and registered outputs use <= so every branch sees pre-edge values.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state            <= IDLE;
            r_cnt              <= '0;
            r_idx              <= '0;
            r_data             <= '0;
            r_stop_idx         <= 1'b0;
            r_frame_acc        <= 1'b0;
            r_par_bit          <= 1'b0;
            r_par_err          <= 1'b0;
            io_Rx.o_RX_DV      <= 1'b0;
            io_Rx.o_RX_Byte    <= '0;
            io_Rx.o_Parity_Err <= 1'b0;
            io_Rx.o_Frame_Err  <= 1'b0;
            io_Rx.o_Break      <= 1'b0;
        end else begin
            io_Rx.o_RX_DV <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end

                START: begin
                    if (r_cnt == CNT_MID) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        if (!w_rx) begin
                            r_state     <= DATA;
                            r_stop_idx  <= 1'b0;
                            r_frame_acc <= 1'b0;
                            r_par_bit   <= 1'b0;
                            r_par_err   <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt  <= '0;
                        // LSB first: after DATA_BITS shifts the first bit lands in bit 0.
                        r_data <= {w_rx, r_data[DATA_BITS-1:1]};
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= HAS_PARITY ? PARITY : STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_par_bit <= w_rx;
                        r_par_err <= (^r_data) ^ w_rx ^ ODD_PARITY;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_last_stop) begin
                            r_state            <= DONE;
                            io_Rx.o_RX_DV      <= 1'b1;
                            io_Rx.o_RX_Byte    <= r_data;
                            io_Rx.o_Parity_Err <= r_par_err;
                            io_Rx.o_Frame_Err  <= w_frame_err;
                            io_Rx.o_Break      <= w_break;
                        end else begin
                            r_stop_idx  <= 1'b1;
                            r_frame_acc <= w_frame_err;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DONE: begin
                    // A line still low here is a break or stuck line, not a new start bit.
                    r_state <= w_rx ? IDLE : WAIT_HI;
                end

                WAIT_HI: begin
                    if (w_rx) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_Rx.o_Busy = (r_state != IDLE);
endmodule
